mem_arbiter: RTL and testbench

//   Shares one line-granular main_mem port between two cache controllers (port 0 = D-cache, port 1 = I-cache).

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-granular main_mem port between two cache
// controllers (master 0 = D-cache, master 1 = I-cache).
//
// Each master drives the line handshake it would drive into main_mem directly.
// An owner is chosen and registered in IDLE. In OWN the owner's request,
// address and write line pass straight through to main_mem. mem_gnt is routed
// back only to the owner. The read line is broadcast to both masters.
//
// Handshake: mk_rd_req / mk_wr_req are held by the master until mk_gnt.
// mk_gnt is a 1-cycle pulse in the same cycle as mem_gnt. If a master drops
// its request before the grant, the transfer is aborted.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m{0,1}_rd_req/wr_req       master line read / write request
//   m{0,1}_addr, m{0,1}_wr_line master line address and write line
//   m{0,1}_gnt                 master transfer-complete pulse
//   rd_line                    main_mem read line, broadcast unregistered
//   owner                      current/last owner index
//   busy                       1 while in state OWN (exposes the FSM state)
//   mem_rd_req/wr_req/addr/wr_line  forwarded request to main_mem
//   mem_rd_line, mem_gnt       main_mem response
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   -> round-robin arbitration: on a tie the winner is ~last, and
//                last is updated on every completed grant.
//   undefined -> fixed priority: master 0 wins every tie.
module mem_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  localparam int LINE_W       = 32 << LINE_ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_rd_req,
  input  logic                m0_wr_req,
  input  logic [ADDR_LEN-1:0] m0_addr,
  input  logic [LINE_W-1:0]   m0_wr_line,
  output logic                m0_gnt,
  input  logic                m1_rd_req,
  input  logic                m1_wr_req,
  input  logic [ADDR_LEN-1:0] m1_addr,
  input  logic [LINE_W-1:0]   m1_wr_line,
  output logic                m1_gnt,
  output logic [LINE_W-1:0]   rd_line,
  output logic                owner,
  output logic                busy,
  output logic                mem_rd_req,
  output logic                mem_wr_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [LINE_W-1:0]   mem_wr_line,
  input  logic [LINE_W-1:0]   mem_rd_line,
  input  logic                mem_gnt
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t state;

  logic                req0, req1;
  logic                winner;
  logic                own_rd, own_wr, own_req;
  logic [ADDR_LEN-1:0] own_addr;
  logic [LINE_W-1:0]   own_line;
  logic                fwd;
  logic                done;

  assign req0 = m0_rd_req | m0_wr_req;
  assign req1 = m1_rd_req | m1_wr_req;

  // Owner-side request mux.
  always_comb begin
    own_rd   = m0_rd_req;
    own_wr   = m0_wr_req;
    own_addr = m0_addr;
    own_line = m0_wr_line;
    if (owner) begin
      own_rd   = m1_rd_req;
      own_wr   = m1_wr_req;
      own_addr = m1_addr;
      own_line = m1_wr_line;
    end
  end

  assign own_req = own_rd | own_wr;

  // A request is forwarded only while in OWN and the owner still requests.
  // If the owner drops its request, memory sees the request low in that same
  // cycle (abort).
  assign fwd  = (state == OWN) & own_req;
  assign done = fwd & mem_gnt;

  // When both read and write are high, the write wins.
  assign mem_wr_req  = fwd & own_wr;
  assign mem_rd_req  = fwd & own_rd & ~own_wr;
  assign mem_addr    = fwd ? own_addr : '0;
  assign mem_wr_line = fwd ? own_line : '0;

  // A grant in IDLE never reaches a master because done requires OWN.
  assign m0_gnt  = done & ~owner;
  assign m1_gnt  = done & owner;
  assign rd_line = mem_rd_line;
  assign busy    = (state == OWN);

`ifdef MEM_ARB_RR_EN
  logic last;

  // On a tie, the winner is ~last. A sole requester always wins.
  assign winner = (req0 & req1) ? ~last : req1;
`else
  // Fixed priority: master 0 wins whenever it requests.
  assign winner = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner <= winner;
            state <= OWN;
          end
        end
        OWN: begin
          // Return to IDLE on completion or on abort. After a grant, the same
          // master must re-arbitrate before it can be served again.
          if (!own_req || mem_gnt) begin
            state <= IDLE;
          end
`ifdef MEM_ARB_RR_EN
          // The pointer advances only on a completed grant, not on abort.
          if (done) begin
            last <= owner;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// The bench plays main_mem with a random grant latency. Expected transfers
// {owner, wr, rd, addr} are queued when the masters raise requests, and are
// checked in order as the arbiter forwards them.
module tb_mem_arbiter;
  localparam int LINE_ADDR_LEN = 3;
  localparam int ADDR_LEN      = 9;
  localparam int LINE_W        = 32 << LINE_ADDR_LEN;
  localparam int EXP_W         = ADDR_LEN + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                m0_rd_req, m0_wr_req, m0_gnt;
  logic [ADDR_LEN-1:0] m0_addr;
  logic [LINE_W-1:0]   m0_wr_line;
  logic                m1_rd_req, m1_wr_req, m1_gnt;
  logic [ADDR_LEN-1:0] m1_addr;
  logic [LINE_W-1:0]   m1_wr_line;
  logic [LINE_W-1:0]   rd_line;
  logic                owner, busy;
  logic                mem_rd_req, mem_wr_req, mem_gnt;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [LINE_W-1:0]   mem_wr_line, mem_rd_line;

  mem_arbiter #(.LINE_ADDR_LEN(LINE_ADDR_LEN), .ADDR_LEN(ADDR_LEN)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req), .m0_addr(m0_addr),
    .m0_wr_line(m0_wr_line), .m0_gnt(m0_gnt),
    .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req), .m1_addr(m1_addr),
    .m1_wr_line(m1_wr_line), .m1_gnt(m1_gnt),
    .rd_line(rd_line), .owner(owner), .busy(busy),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [EXP_W-1:0] tr(input logic own, input logic wr,
                                          input logic [ADDR_LEN-1:0] a);
    return {own, wr, ~wr, a};
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after posedge; checks are made 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Acts as main_mem for one transfer: waits for a forwarded request, checks
  // it against the queue head, grants after a random latency, and drops the
  // owner's request once it sees its grant.
  task automatic serve(input logic [LINE_W-1:0] wline, output logic who);
    logic [EXP_W-1:0]  e;
    logic [LINE_W-1:0] pat;
    int n;
    int lat;
    n = 0;
    who = 1'b0;
    while (!(mem_rd_req | mem_wr_req) && n < 20) begin
      step();
      #1;
      n++;
    end
    chk("mem_req_seen", mem_rd_req | mem_wr_req, 1);
    chk("exp_q_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    who = e[EXP_W-1];
    chk("xfer", {owner, mem_wr_req, mem_rd_req, mem_addr}, e);
    chk("mem_wr_line", mem_wr_line, wline);
    chk("busy_own", busy, 1);
    lat = $urandom_range(1, 4);
    repeat (lat - 1) begin
      step();
      #1;
      chk("req_held", {mem_wr_req, mem_rd_req, m1_gnt, m0_gnt}, {e[EXP_W-2 -: 2], 2'b00});
    end
    step();
    for (int i = 0; i < LINE_W / 32; i++) pat[32*i +: 32] = $urandom();
    mem_gnt = 1'b1;
    mem_rd_line = pat;
    #1;
    chk("gnt_route", {m1_gnt, m0_gnt}, who ? 2'b10 : 2'b01);
    chk("rd_line", rd_line, pat);
    step();
    mem_gnt = 1'b0;
    if (who) begin
      m1_rd_req = 1'b0;
      m1_wr_req = 1'b0;
    end else begin
      m0_rd_req = 1'b0;
      m0_wr_req = 1'b0;
    end
    #1;
    chk("idle_after_gnt", {busy, m1_gnt, m0_gnt, mem_rd_req, mem_wr_req}, 0);
    chk("rd_line_hold", rd_line, pat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic              who;
    logic [LINE_W-1:0] l2, l4, l6;
    logic [ADDR_LEN-1:0] a0, a1;

    rst = 1'b1;
    m0_rd_req = 0; m0_wr_req = 0; m0_addr = '0; m0_wr_line = '0;
    m1_rd_req = 0; m1_wr_req = 0; m1_addr = '0; m1_wr_line = '0;
    mem_gnt = 0; mem_rd_line = '0;
    for (int i = 0; i < LINE_W / 32; i++) begin
      l2[32*i +: 32] = 32'hA5A5_A500 | i;
      l4[32*i +: 32] = $urandom();
      l6[32*i +: 32] = $urandom();
    end
    repeat (2) step();
    #1;
    chk("reset_state", {owner, busy, m0_gnt, m1_gnt, mem_rd_req, mem_wr_req}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wline", mem_wr_line, 0);
    step();
    rst = 1'b0;

    // Test 1: master 0 read; the memory request appears one cycle after the master request.
    m0_rd_req = 1'b1;
    m0_addr = 9'h012;
    exp_q.push_back(tr(1'b0, 1'b0, 9'h012));
    #1;
    chk("t1_idle_no_fwd", {mem_rd_req, busy}, 0);
    step();
    #1;
    chk("t1_fwd_t_plus_1", mem_rd_req, 1);
    serve('0, who);

    // Test 2: master 1 write line.
    m1_wr_req = 1'b1;
    m1_addr = 9'h0A5;
    m1_wr_line = l2;
    exp_q.push_back(tr(1'b1, 1'b1, 9'h0A5));
    serve(l2, who);
    m1_wr_line = '0;

    // Test 3: both masters keep requesting. The served master re-raises its
    // request for the first three grants.
    a0 = 9'h030;
    a1 = 9'h140;
`ifdef MEM_ARB_RR_EN
    exp_q.push_back(tr(1'b0, 1'b0, 9'h030));
    exp_q.push_back(tr(1'b1, 1'b0, 9'h140));
    exp_q.push_back(tr(1'b0, 1'b0, 9'h031));
    exp_q.push_back(tr(1'b1, 1'b0, 9'h141));
    exp_q.push_back(tr(1'b0, 1'b0, 9'h032));
`else
    exp_q.push_back(tr(1'b0, 1'b0, 9'h030));
    exp_q.push_back(tr(1'b0, 1'b0, 9'h031));
    exp_q.push_back(tr(1'b0, 1'b0, 9'h032));
    exp_q.push_back(tr(1'b0, 1'b0, 9'h033));
    exp_q.push_back(tr(1'b1, 1'b0, 9'h140));
`endif
    m0_rd_req = 1'b1; m0_addr = a0;
    m1_rd_req = 1'b1; m1_addr = a1;
    for (int i = 0; i < 5; i++) begin
      serve('0, who);
      if (i < 3) begin
        if (who) begin
          a1 = a1 + 1'b1; m1_addr = a1; m1_rd_req = 1'b1;
        end else begin
          a0 = a0 + 1'b1; m0_addr = a0; m0_rd_req = 1'b1;
        end
      end
    end

    // Test 4: master 0 swap-out write then swap-in read while master 1 waits.
    m0_wr_req = 1'b1;
    m0_addr = 9'h055;
    m0_wr_line = l4;
    exp_q.push_back(tr(1'b0, 1'b1, 9'h055));
`ifdef MEM_ARB_RR_EN
    exp_q.push_back(tr(1'b1, 1'b0, 9'h1AA));
    exp_q.push_back(tr(1'b0, 1'b0, 9'h055));
`else
    exp_q.push_back(tr(1'b0, 1'b0, 9'h055));
    exp_q.push_back(tr(1'b1, 1'b0, 9'h1AA));
`endif
    #1;
    step();
    m1_rd_req = 1'b1;
    m1_addr = 9'h1AA;
    serve(l4, who);
    m0_wr_line = '0;
    m0_rd_req = 1'b1;
    serve('0, who);
    serve('0, who);

    // Test 5: the owner aborts before the grant.
    m0_rd_req = 1'b1;
    m0_addr = 9'h077;
    #1;
    step();
    #1;
    chk("t5_own", {busy, mem_rd_req}, 2'b11);
    step();
    m0_rd_req = 1'b0;
    #1;
    chk("t5_abort_same_cycle", {mem_rd_req, mem_wr_req, m0_gnt, m1_gnt}, 0);
    chk("t5_abort_addr", mem_addr, 0);
    step();
    #1;
    chk("t5_idle", {busy, mem_rd_req, m0_gnt, m1_gnt}, 0);

    // Test 6: reset during OWN, then a spurious grant in IDLE, then re-arbitration.
    m1_wr_req = 1'b1;
    m1_addr = 9'h0F0;
    m1_wr_line = l6;
    #1;
    step();
    #1;
    chk("t6_own_m1", {owner, busy}, 2'b11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_gnt = 1'b1;
    #1;
    chk("t6_reset_ctl", {owner, busy, m0_gnt, m1_gnt, mem_rd_req, mem_wr_req}, 0);
    chk("t6_reset_addr", mem_addr, 0);
    chk("t6_reset_wline", mem_wr_line, 0);
    step();
    mem_gnt = 1'b0;
    exp_q.push_back(tr(1'b1, 1'b1, 9'h0F0));
    serve(l6, who);

    chk("exp_q_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
